// File: rtl/qoi_enc_ctrl.sv
// QOI encoder sequencer: pixel classification, chunk emission
// and end marker on a valid/ready byte stream.
module qoi_enc_ctrl #(
  parameter int SIZE_W  = 30,
  parameter int RUN_MAX = 62
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] pixel_count,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [31:0]       px_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              busy,
  output logic              done,
  output logic [SIZE_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CLASS, S_EMIT, S_FLUSH, S_TAIL
  } state_t;

  state_t            state_q;
  logic [SIZE_W-1:0] pc_q;
  logic [SIZE_W-1:0] count_q;
  logic [31:0]       px_q;
  logic [31:0]       prev_q;
  logic [5:0]        run_q;
  logic [63:0]       vld_q;
  logic [31:0]       idx_q [64];
  logic [39:0]       rest_q;
  logic [2:0]        left_q;
  logic [2:0]        tcnt_q;
  logic              px_ready_q;
  logic              byte_valid_q;
  logic [7:0]        byte_data_q;
  logic              busy_q;
  logic              done_q;

  logic [7:0]  r, g, b, a;
  logic [12:0] hsum;
  logic [5:0]  hash;
  logic        same, hit;
  logic [5:0]  run_inc;
  logic [7:0]  dr, dg, db, dr2, dg2, db2;
  logic [7:0]  dg32, rg8, bg8;
  logic [39:0] ch;
  logic [2:0]  cl;
  logic [47:0] out_buf;
  logic [2:0]  out_n;
  logic [7:0]  run_byte;

  assign r = px_q[7:0];
  assign g = px_q[15:8];
  assign b = px_q[23:16];
  assign a = px_q[31:24];

  assign hsum = 13'(r) * 13'd3 + 13'(g) * 13'd5
              + 13'(b) * 13'd7 + 13'(a) * 13'd11;
  assign hash = hsum[5:0];
  assign same = (px_q == prev_q);
  assign hit  = vld_q[hash] && (idx_q[hash] == px_q);
  assign run_inc  = run_q + 6'd1;
  assign run_byte = {2'b11, run_q - 6'd1};

  // Wrapping channel differences, biased so range tests are unsigned
  assign dr   = r - prev_q[7:0];
  assign dg   = g - prev_q[15:8];
  assign db   = b - prev_q[23:16];
  assign dr2  = dr + 8'd2;
  assign dg2  = dg + 8'd2;
  assign db2  = db + 8'd2;
  assign dg32 = dg + 8'd32;
  assign rg8  = dr - dg + 8'd8;
  assign bg8  = db - dg + 8'd8;

  // Chunk for a non-run pixel, left-aligned, highest precedence first
  always_comb begin
    ch = '0;
    cl = 3'd0;
    if (hit) begin
      ch = {2'b00, hash, 32'h0};
      cl = 3'd1;
    end else if (a == prev_q[31:24]) begin
      if (dr2 < 8'd4 && dg2 < 8'd4 && db2 < 8'd4) begin
        ch = {2'b01, dr2[1:0], dg2[1:0], db2[1:0], 32'h0};
        cl = 3'd1;
      end else if (dg32 < 8'd64 && rg8 < 8'd16 && bg8 < 8'd16) begin
        ch = {2'b10, dg32[5:0], rg8[3:0], bg8[3:0], 24'h0};
        cl = 3'd2;
      end else begin
        ch = {8'hFE, r, g, b, 8'h0};
        cl = 3'd4;
      end
    end else begin
      ch = {8'hFF, r, g, b, a};
      cl = 3'd5;
    end
  end

  // Full output buffer: optional pending run byte, then the chunk
  always_comb begin
    out_buf = '0;
    out_n   = 3'd0;
    if (same) begin
      if (run_inc == 6'(RUN_MAX)) begin
        out_buf = {2'b11, 6'(RUN_MAX - 1), 40'h0};
        out_n   = 3'd1;
      end
    end else if (run_q != 6'd0) begin
      out_buf = {run_byte, ch};
      out_n   = cl + 3'd1;
    end else begin
      out_buf = {ch, 8'h0};
      out_n   = cl;
    end
  end

  // Index table payload; validity is tracked separately so start clears it
  always_ff @(posedge clk) begin
    if (state_q == S_CLASS && !same && !hit)
      idx_q[hash] <= px_q;
  end

  // Main sequencer with registered handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      count_q      <= '0;
      px_q         <= '0;
      prev_q       <= '0;
      run_q        <= '0;
      vld_q        <= '0;
      rest_q       <= '0;
      left_q       <= '0;
      tcnt_q       <= '0;
      px_ready_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q       <= pixel_count;
            count_q    <= '0;
            prev_q     <= 32'hFF00_0000;
            run_q      <= '0;
            vld_q      <= '0;
            busy_q     <= 1'b1;
            px_ready_q <= (pixel_count != '0);
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (count_q == pc_q) begin
            px_ready_q <= 1'b0;
            state_q    <= S_FLUSH;
          end else if (px_valid && px_ready_q) begin
            px_q       <= px_data;
            count_q    <= count_q + SIZE_W'(1);
            px_ready_q <= 1'b0;
            state_q    <= S_CLASS;
          end
        end
        S_CLASS: begin
          if (same) begin
            run_q <= (run_inc == 6'(RUN_MAX)) ? 6'd0 : run_inc;
          end else begin
            run_q  <= '0;
            prev_q <= px_q;
            if (!hit) vld_q[hash] <= 1'b1;
          end
          if (out_n != 3'd0) begin
            byte_valid_q <= 1'b1;
            byte_data_q  <= out_buf[47:40];
            rest_q       <= out_buf[39:0];
            left_q       <= out_n - 3'd1;
            state_q      <= S_EMIT;
          end else begin
            px_ready_q <= (count_q != pc_q);
            state_q    <= S_FETCH;
          end
        end
        S_EMIT: begin
          if (byte_ready) begin
            if (left_q == 3'd0) begin
              byte_valid_q <= 1'b0;
              px_ready_q   <= (count_q != pc_q);
              state_q      <= S_FETCH;
            end else begin
              byte_data_q <= rest_q[39:32];
              rest_q      <= {rest_q[31:0], 8'h0};
              left_q      <= left_q - 3'd1;
            end
          end
        end
        S_FLUSH: begin
          if (byte_valid_q) begin
            if (byte_ready) begin
              byte_data_q <= 8'h00;
              tcnt_q      <= '0;
              state_q     <= S_TAIL;
            end
          end else if (run_q != 6'd0) begin
            byte_valid_q <= 1'b1;
            byte_data_q  <= run_byte;
            run_q        <= '0;
          end else begin
            byte_valid_q <= 1'b1;
            byte_data_q  <= 8'h00;
            tcnt_q       <= '0;
            state_q      <= S_TAIL;
          end
        end
        S_TAIL: begin
          if (byte_ready) begin
            if (tcnt_q == 3'd7) begin
              byte_valid_q <= 1'b0;
              byte_data_q  <= 8'h00;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              tcnt_q      <= tcnt_q + 3'd1;
              byte_data_q <= (tcnt_q == 3'd6) ? 8'h01 : 8'h00;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign px_ready   = px_ready_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_qoi_enc_ctrl.sv
// Directed bench for qoi_enc_ctrl: table of small images plus
// run-limit, backpressure and reset sequences.
module tb_qoi_enc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [29:0] pixel_count = '0;
  logic        px_valid = 1'b0;
  logic        px_ready;
  logic [31:0] px_data = '0;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        busy;
  logic        done;
  logic [29:0] count;

  int checks = 0;
  int failures = 0;
  logic [31:0] pix [64];

  qoi_enc_ctrl #(.SIZE_W(30), .RUN_MAX(62)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pixel_count(pixel_count),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_data(byte_data),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           npx;
    logic [31:0]  p0, p1, p2;
    int           nb;
    logic [159:0] ex;
    bit           stall;
    bit           ign;
  } vec_t;

  vec_t vt [6];

  function automatic logic [31:0] pxf(int r, int g, int b, int a);
    return {8'(a), 8'(b), 8'(g), 8'(r)};
  endfunction

  function automatic logic [159:0] la(logic [159:0] e, int nb);
    return e << (8 * (20 - nb));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_img(string nm, int npx, int nb,
                         logic [159:0] ex, bit stall, bit ign);
    logic [7:0] got [$];
    int pi;
    int cyc;
    bit fin;
    bit stalled;
    logic [7:0] eb;
    pi = 0; cyc = 0; fin = 0; stalled = 0;
    @(negedge clk);
    pixel_count = 30'(npx);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".busy"}, 32'(busy), 32'd1);
    while (!fin && cyc < 2000) begin
      cyc++;
      if (done) begin
        fin = 1;
      end else begin
        byte_ready = 1'b1;
        start = (ign && cyc == 3);
        pixel_count = (ign && cyc == 3) ? 30'(npx + 5) : 30'(npx);
        px_valid = (pi < npx);
        px_data = (pi < npx) ? pix[pi] : 32'h0;
        if (stall && !stalled && byte_valid && byte_data == 8'hFE) begin
          stalled = 1;
          byte_ready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            chk({nm, ".stall_valid"}, 32'(byte_valid), 32'd1);
            chk({nm, ".stall_data"}, 32'(byte_data), 32'hFE);
            chk({nm, ".stall_pxrdy"}, 32'(px_ready), 32'd0);
          end
          byte_ready = 1'b1;
        end
        if (px_valid && px_ready) pi++;
        if (byte_valid && byte_ready) got.push_back(byte_data);
        @(negedge clk);
      end
    end
    start = 1'b0;
    px_valid = 1'b0;
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout actual=no_done required=done", nm);
    end
    chk({nm, ".len"}, 32'(got.size()), 32'(nb));
    for (int k = 0; k < nb; k++) begin
      eb = ex[159 - 8 * k -: 8];
      chk($sformatf("%s.byte%0d", nm, k),
          (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(eb));
    end
    chk({nm, ".count"}, 32'(count), 32'(npx));
    chk({nm, ".busy_end"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({nm, ".done_pulse"}, 32'(done), 32'd0);
    chk({nm, ".count_hold"}, 32'(count), 32'(npx));
  endtask

  localparam logic [63:0] MK = 64'h1;

  initial begin
    vt[0] = '{3, pxf(0,0,0,255), pxf(0,0,0,255), pxf(0,0,0,255),
              9, la({8'hC2, MK}, 9), 0, 1};
    vt[1] = '{1, pxf(1,0,255,255), 0, 0,
              9, la({8'h79, MK}, 9), 0, 0};
    vt[2] = '{1, pxf(20,16,14,255), 0, 0,
              10, la({8'hB0, 8'hC6, MK}, 10), 0, 0};
    vt[3] = '{3, pxf(100,0,0,255), pxf(0,0,0,128), pxf(100,0,0,255),
              18, la({32'hFE64_0000, 40'hFF00_0000_80, 8'h21, MK}, 18),
              1, 0};
    vt[4] = '{0, 0, 0, 0, 8, la({MK}, 8), 0, 0};
    vt[5] = '{2, pxf(0,0,0,255), pxf(1,0,255,255), 0,
              10, la({8'hC0, 8'h79, MK}, 10), 0, 0};

    repeat (2) @(negedge clk);
    chk("rst.px_ready", 32'(px_ready), 32'd0);
    chk("rst.byte_valid", 32'(byte_valid), 32'd0);
    chk("rst.byte_data", 32'(byte_data), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pix[0] = vt[i].p0;
      pix[1] = vt[i].p1;
      pix[2] = vt[i].p2;
      run_img($sformatf("v%0d", i), vt[i].npx, vt[i].nb, vt[i].ex,
              vt[i].stall, vt[i].ign);
    end

    for (int i = 0; i < 64; i++) pix[i] = pxf(0,0,0,255);
    run_img("runmax", 64, 10, la({8'hFD, 8'hC1, MK}, 10), 0, 0);

    pix[0] = pxf(100,0,0,255);
    pix[1] = pxf(0,0,0,128);
    @(negedge clk);
    pixel_count = 30'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    px_valid = 1'b1;
    px_data = pix[0];
    for (int c = 0; c < 50 && !byte_valid; c++) @(negedge clk);
    chk("mid.byte_valid", 32'(byte_valid), 32'd1);
    chk("mid.count", 32'(count), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.byte_valid", 32'(byte_valid), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.count", 32'(count), 32'd0);
    px_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    pix[0] = pxf(100,0,0,255);
    run_img("fresh", 1, 12, la({32'hFE64_0000, MK}, 12), 0, 0);

    pix[0] = pxf(100,0,0,255);
    pix[1] = pxf(100,0,0,255);
    run_img("fresh_run", 2, 13, la({32'hFE64_0000, 8'hC0, MK}, 13), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
